// File: rtl/result_address_ctrl_pkg.sv
// Shared types and constants for the result-memory address controller.
package result_addr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    // One result slot holds a maximum-size Ethernet frame (1550 bytes).
    localparam logic [31:0] RESULT_SLOT_STRIDE = 32'h0000_060E;
    localparam logic [31:0] RESULT_BASE_ADDR   = 32'h0000_0000;

endpackage

// File: rtl/result_address_ctrl.sv
// Result-memory address generator for the Ethernet sniffer result path.
// Each accepted inc_addr request advances addr_out by one slot stride and
// raises write_enable for exactly one cycle alongside the new address.
// A held request produces a single increment; inc_addr must be seen low
// before the next request is accepted.
// Optional build macro: RESULT_ADDR_WRAP_EN -- when defined, an increment
// that would pass ADDR_LIMIT restarts at BASE_ADDR + ADDR_STRIDE.
module result_address_ctrl
    import result_addr_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(RESULT_BASE_ADDR),
    parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(RESULT_SLOT_STRIDE),
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  inc_addr,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  write_enable
);

    state_t                state_reg;
    state_t                state_next;
    logic                  load_next;
    logic                  we_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH:0]   addr_sum;

    // State register with immediate (asynchronous) reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an unknown inc_addr falls through to the "low" branch.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                case (inc_addr)
                    1'b1:    state_next = WRITE;
                    default: state_next = IDLE;
                endcase
            end
            WRITE: begin
                case (inc_addr)
                    1'b1:    state_next = WAIT_LOW;
                    default: state_next = IDLE;
                endcase
            end
            WAIT_LOW: begin
                case (inc_addr)
                    1'b1:    state_next = WAIT_LOW;
                    default: state_next = IDLE;
                endcase
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: the strobe and the address load both follow entry into WRITE,
    // so registering them keeps write_enable aligned with the updated address.
    always_comb begin
        we_next   = (state_next == WRITE);
        load_next = (state_reg == IDLE) && (state_next == WRITE);
    end

    // Address adder; the extra top bit carries the overflow for the limit test.
    always_comb begin
        addr_sum = {1'b0, addr_reg} + {1'b0, ADDR_STRIDE};
`ifdef RESULT_ADDR_WRAP_EN
        if (addr_sum > {1'b0, ADDR_LIMIT}) begin
            addr_next = BASE_ADDR + ADDR_STRIDE;
        end else begin
            addr_next = addr_sum[ADDR_WIDTH-1:0];
        end
`else
        addr_next = addr_sum[ADDR_WIDTH-1:0];
`endif
    end

    // Address and strobe registers; the address holds between accepted requests.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_reg     <= BASE_ADDR;
            write_enable <= 1'b0;
        end else begin
            write_enable <= we_next;
            if (load_next) begin
                addr_reg <= addr_next;
            end
        end
    end

    assign addr_out = addr_reg;

endmodule

// File: tb/tb_result_address_ctrl.sv
// Self-checking bench for result_address_ctrl: a vector table for the
// deterministic sequences, a hand-written asynchronous-reset sequence,
// and randomized requests checked against a request-level model.
module tb_result_address_ctrl;

    localparam logic [31:0] STRIDE = 32'h0000_060E;
    localparam logic [31:0] LIMIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'hFFFF_F000;

    logic        clk;
    logic        n_rst;
    logic        inc_a;
    logic        inc_b;
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic        we_a;
    logic        we_b;

    int errors = 0;
    int checks = 0;

    result_address_ctrl dut_a (
        .clk          (clk),
        .n_rst        (n_rst),
        .inc_addr     (inc_a),
        .addr_out     (addr_a),
        .write_enable (we_a)
    );

    result_address_ctrl #(
        .BASE_ADDR (BASE_B)
    ) dut_b (
        .clk          (clk),
        .n_rst        (n_rst),
        .inc_addr     (inc_b),
        .addr_out     (addr_b),
        .write_enable (we_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;   // 1 = hold reset asserted during this cycle
        bit          inc;
        logic [31:0] addr;
        bit          we;
    } vec_t;

    vec_t vecs[$];

    // Request-level model: a request is taken when inc is high and inc has
    // been seen low since the previous taken request.
    logic [31:0] m_addr_a, m_addr_b;
    bit          m_we_a, m_we_b;
    bit          m_need_low_a, m_need_low_b;

    function automatic logic [31:0] next_slot(input logic [31:0] a, input logic [31:0] base);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, STRIDE};
`ifdef RESULT_ADDR_WRAP_EN
        if (s > {1'b0, LIMIT}) return base + STRIDE;
`endif
        return s[31:0];
    endfunction

    task automatic model_reset();
        m_addr_a = BASE_A; m_we_a = 0; m_need_low_a = 0;
        m_addr_b = BASE_B; m_we_b = 0; m_need_low_b = 0;
    endtask

    task automatic model_edge(input bit ia, input bit ib);
        m_we_a = ia && !m_need_low_a;
        if (m_we_a) begin
            m_addr_a = next_slot(m_addr_a, BASE_A);
            m_need_low_a = 1;
        end else if (!ia) begin
            m_need_low_a = 0;
        end
        m_we_b = ib && !m_need_low_b;
        if (m_we_b) begin
            m_addr_b = next_slot(m_addr_b, BASE_B);
            m_need_low_b = 1;
        end else if (!ib) begin
            m_need_low_b = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic cycle(input bit rst, input bit ia, input bit ib);
        @(negedge clk);
        n_rst = rst ? 1'b0 : 1'b1;
        inc_a = ia;
        inc_b = ib;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(ia, ib);
        #1;
    endtask

    task automatic add(input bit rst, input bit inc, input logic [31:0] addr, input bit we);
        vec_t v;
        v.rst = rst; v.inc = inc; v.addr = addr; v.we = we;
        vecs.push_back(v);
    endtask

    initial begin
        n_rst = 1'b0;
        inc_a = 1'b0;
        inc_b = 1'b0;
        model_reset();

        // Reset, then four isolated pulses.
        add(1, 0, 32'h0, 0); add(1, 0, 32'h0, 0);
        add(0, 0, 32'h0, 0); add(0, 0, 32'h0, 0);
        add(0, 1, 32'h060E, 1); add(0, 0, 32'h060E, 0); add(0, 0, 32'h060E, 0);
        add(0, 1, 32'h0C1C, 1); add(0, 0, 32'h0C1C, 0); add(0, 0, 32'h0C1C, 0);
        add(0, 1, 32'h122A, 1); add(0, 0, 32'h122A, 0); add(0, 0, 32'h122A, 0);
        add(0, 1, 32'h1838, 1); add(0, 0, 32'h1838, 0); add(0, 0, 32'h1838, 0);
        // Held request: five high cycles give one increment.
        add(1, 0, 32'h0, 0);
        add(0, 1, 32'h060E, 1); add(0, 0, 32'h060E, 0);
        add(0, 1, 32'h0C1C, 1); add(0, 1, 32'h0C1C, 0); add(0, 1, 32'h0C1C, 0);
        add(0, 1, 32'h0C1C, 0); add(0, 1, 32'h0C1C, 0);
        add(0, 0, 32'h0C1C, 0);
        add(0, 1, 32'h122A, 1); add(0, 0, 32'h122A, 0);
        // Back-to-back alternating pulses from reset.
        add(1, 0, 32'h0, 0);
        add(0, 1, 32'h060E, 1); add(0, 0, 32'h060E, 0);
        add(0, 1, 32'h0C1C, 1); add(0, 0, 32'h0C1C, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].inc, 1'b0);
            chk($sformatf("vec%0d addr", i), addr_a, vecs[i].addr);
            chk($sformatf("vec%0d we", i), {31'b0, we_a}, {31'b0, vecs[i].we});
        end

        // Asynchronous reset while in WRITE at 0x0C1C.
        cycle(1, 0, 0);
        cycle(0, 1, 0); cycle(0, 0, 0);
        cycle(0, 1, 0);
        chk("pre_async addr", addr_a, 32'h0C1C);
        chk("pre_async we", {31'b0, we_a}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("async addr", addr_a, 32'h0);
        chk("async we", {31'b0, we_a}, 32'd0);
        model_reset();
        cycle(0, 1, 0);
        chk("post_async addr", addr_a, 32'h060E);
        chk("post_async we", {31'b0, we_a}, 32'd1);

        // Overflow on the high-based instance: three pulses cross 2^32.
        cycle(1, 0, 0);
        chk("hi reset addr", addr_b, BASE_B);
        for (int p = 0; p < 3; p++) begin
            cycle(0, 0, 1);
            chk($sformatf("hi pulse%0d we", p), {31'b0, we_b}, 32'd1);
            cycle(0, 0, 0);
            chk($sformatf("hi pulse%0d addr", p), addr_b, m_addr_b);
        end
`ifndef RESULT_ADDR_WRAP_EN
        chk("hi modulo", addr_b, 32'h0000_022A);
`endif

        // Randomized requests on both instances, with occasional resets.
        cycle(1, 0, 0);
        for (int n = 0; n < 400; n++) begin
            bit r, ia, ib;
            r  = ($urandom_range(0, 99) == 0);
            ia = $urandom_range(0, 1);
            ib = ($urandom_range(0, 2) != 0);
            cycle(r, ia, ib);
            chk($sformatf("rnd%0d addr_a", n), addr_a, m_addr_a);
            chk($sformatf("rnd%0d we_a", n), {31'b0, we_a}, {31'b0, m_we_a});
            chk($sformatf("rnd%0d addr_b", n), addr_b, m_addr_b);
            chk($sformatf("rnd%0d we_b", n), {31'b0, we_b}, {31'b0, m_we_b});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
